// File: rtl/jcs_slot_arb.sv
// rtl/jcs_slot_arb.sv - time-division slot arbiter driven by an N-bit Johnson ring
// Requester k owns slot k; the ring parks on a slot only while its owner holds the grant.
module jcs_slot_arb #(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int M        = 2 * N,
  localparam int SW       = $clog2(M)
) (
  input  logic          i_clk,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic [M-1:0]  i_req,
  input  logic          i_release,
  output logic [M-1:0]  o_gnt,
  output logic          o_gnt_vld,
  output logic [SW-1:0] o_gnt_id,
  output logic          o_tmo,
  output logic [N-1:0]  o_ring
);

  localparam int             CW       = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0]  HOLD_MAX = CW'(MAX_HOLD);
  localparam logic [SW-1:0]  M_MOD    = SW'(M);

  typedef enum logic {SCAN, GRANT} state_t;

  state_t        r_state;
  logic [N-1:0]  r_ring;
  logic [CW-1:0] r_cnt;
  logic [M-1:0]  r_gnt;
  logic          r_gnt_vld;
  logic [SW-1:0] r_gnt_id;
  logic          r_tmo;

  logic [SW-1:0] w_pop;
  logic [SW-1:0] w_slot;
  logic [N-1:0]  w_ring_nxt;
  logic          w_cut;
  logic          w_tout;

  // Modular subtraction keeps 2N - popcount correct even when 2N wraps to zero in SW bits.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N; i++) begin
      w_pop = w_pop + SW'(r_ring[i]);
    end
    w_slot = r_ring[N-1] ? (M_MOD - w_pop) : w_pop;
  end

  assign w_ring_nxt = {r_ring[N-2:0], ~r_ring[N-1]};
  assign w_cut      = i_release | ~i_req[r_gnt_id];
  assign w_tout     = (r_cnt == HOLD_MAX);

  always_ff @(posedge i_clk or negedge i_clr) begin
    if (!i_clr) begin
      r_state   <= SCAN;
      r_ring    <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_gnt_vld <= 1'b0;
      r_gnt_id  <= '0;
      r_tmo     <= 1'b0;
    end else begin
      r_tmo <= 1'b0;
      case (r_state)
        SCAN: begin
          if (i_en) begin
            if (i_req[w_slot]) begin
              r_state   <= GRANT;
              r_gnt     <= M'(1) << w_slot;
              r_gnt_vld <= 1'b1;
              r_gnt_id  <= w_slot;
              r_cnt     <= CW'(1);
            end else begin
              r_ring <= w_ring_nxt;
            end
          end
        end
        GRANT: begin
          // Release or request drop outranks a coincident timeout, so tmo flags pure timeouts.
          if (w_cut || w_tout) begin
            r_state   <= SCAN;
            r_ring    <= w_ring_nxt;
            r_gnt     <= '0;
            r_gnt_vld <= 1'b0;
            r_gnt_id  <= '0;
            r_cnt     <= '0;
            r_tmo     <= ~w_cut;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  assign o_gnt     = r_gnt;
  assign o_gnt_vld = r_gnt_vld;
  assign o_gnt_id  = r_gnt_id;
  assign o_tmo     = r_tmo;
  assign o_ring    = r_ring;

endmodule

// File: tb/tb_jcs_slot_arb.sv
// tb/tb_jcs_slot_arb.sv - scoreboard bench for jcs_slot_arb against a slot-level reference model
module tb_jcs_slot_arb;

  localparam int N  = 4;
  localparam int MH = 4;
  localparam int M  = 2 * N;

  logic         i_clk = 1'b0;
  logic         i_clr = 1'b0;
  logic         i_en = 1'b0;
  logic [M-1:0] i_req = '0;
  logic         i_release = 1'b0;
  logic [M-1:0] o_gnt;
  logic         o_gnt_vld;
  logic [2:0]   o_gnt_id;
  logic         o_tmo;
  logic [N-1:0] o_ring;

  jcs_slot_arb #(.N(N), .MAX_HOLD(MH)) dut (
    .i_clk(i_clk), .i_clr(i_clr), .i_en(i_en), .i_req(i_req), .i_release(i_release),
    .o_gnt(o_gnt), .o_gnt_vld(o_gnt_vld), .o_gnt_id(o_gnt_id), .o_tmo(o_tmo), .o_ring(o_ring)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic         tmo;
    logic         vld;
    logic [2:0]   id;
    logic [M-1:0] gnt;
    logic [N-1:0] ring;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  int m_slot = 0;
  bit m_granted = 0;
  int m_hold = 0;
  int m_gid = 0;
  bit m_tmo = 0;

  // Ring pattern for slot s: s ones filling from bit 0, then zeros filling from bit 0.
  function automatic logic [N-1:0] ring_of(int s);
    int v;
    if (s <= N) v = (1 << s) - 1;
    else        v = ((1 << N) - 1) & ~((1 << (s - N)) - 1);
    return N'(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  task automatic model_step(bit clr, bit en, logic [M-1:0] req, bit rel);
    bit cut;
    m_tmo = 0;
    if (!clr) begin
      m_slot = 0; m_granted = 0; m_hold = 0; m_gid = 0;
      return;
    end
    if (!m_granted) begin
      if (en) begin
        if (req[m_slot]) begin
          m_granted = 1; m_gid = m_slot; m_hold = 1;
        end else begin
          m_slot = (m_slot + 1) % M;
        end
      end
    end else begin
      cut = rel || !req[m_gid];
      if (cut || m_hold == MH) begin
        m_granted = 0; m_tmo = !cut; m_slot = (m_slot + 1) % M; m_hold = 0; m_gid = 0;
      end else begin
        m_hold++;
      end
    end
  endtask

  task automatic cycle(bit clr, bit en, logic [M-1:0] req, bit rel);
    exp_t e;
    @(negedge i_clk);
    i_clr = clr; i_en = en; i_req = req; i_release = rel;
    model_step(clr, en, req, rel);
    e.tmo  = m_tmo;
    e.vld  = m_granted;
    e.id   = m_granted ? 3'(m_gid) : 3'd0;
    e.gnt  = m_granted ? M'(1 << m_gid) : '0;
    e.ring = ring_of(m_slot);
    q.push_back(e);
  endtask

  always @(posedge i_clk) begin
    exp_t e;
    exp_t a;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      a = {o_tmo, o_gnt_vld, o_gnt_id, o_gnt, o_ring};
      check("outputs{tmo,vld,id,gnt,ring}", 32'(a), 32'(e));
    end
  end

  initial begin
    int k;
    #2;
    check("reset_ring", 32'(o_ring), 32'h0);
    check("reset_gnt", 32'(o_gnt), 32'h0);

    // Reset then free run across a full lap and a bit.
    cycle(0, 1, '0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 1, '0, 0);

    // Single grant on slot 3 with a release three cycles in.
    k = 0;
    while (!m_granted && k < 40) begin cycle(1, 1, 8'h08, 0); k++; end
    check("single_grant_reached", 32'(m_granted), 32'h1);
    cycle(1, 1, 8'h08, 0);
    cycle(1, 1, 8'h08, 0);
    cycle(1, 1, 8'h08, 1);
    for (int i = 0; i < 3; i++) cycle(1, 1, '0, 0);

    // Timeout on slot 5, then a re-grant after a lap.
    for (int i = 0; i < 30; i++) cycle(1, 1, 8'h20, 0);

    // Everyone requesting, release one cycle after each grant.
    for (int i = 0; i < 24; i++) cycle(1, 1, 8'hFF, m_granted);

    // Enable gating in SCAN at slot 2 and during a grant.
    k = 0;
    while (m_slot != 2 && k < 40) begin cycle(1, 1, '0, 0); k++; end
    for (int i = 0; i < 5; i++) cycle(1, 0, '0, 0);
    cycle(1, 1, 8'h04, 0);
    cycle(1, 0, 8'h04, 0);
    cycle(1, 0, 8'h04, 0);
    cycle(1, 0, 8'h04, 1);
    cycle(1, 1, '0, 0);

    // Asynchronous reset while slot 2 holds the grant.
    k = 0;
    while (!(m_granted && m_gid == 2) && k < 40) begin cycle(1, 1, 8'h04, 0); k++; end
    @(posedge i_clk);
    #2;
    check("pre_reset_gnt", 32'(o_gnt), 32'h04);
    i_clr = 1'b0;
    #1;
    check("async_rst_gnt", 32'(o_gnt), 32'h0);
    check("async_rst_vld", 32'(o_gnt_vld), 32'h0);
    check("async_rst_tmo", 32'(o_tmo), 32'h0);
    check("async_rst_ring", 32'(o_ring), 32'h0);
    check("async_rst_id", 32'(o_gnt_id), 32'h0);
    model_step(0, 1, '0, 0);
    cycle(0, 1, 8'h04, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 8'h04, 0);

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) != 0),
            M'($urandom), ($urandom_range(0, 5) == 0));
    end

    cycle(1, 0, '0, 0);
    @(posedge i_clk);
    #3;
    check("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/jcs_slot_arb.md
# jcs_slot_arb

Time-division slot arbiter built around an internal N-bit Johnson ring (2N slots). It shares one downstream resource among 2N requesters: requester k owns slot k, and the ring idles on a slot only while that slot's owner holds the grant. The arbiter sits between requesting units and the shared resource and exposes the raw ring state for observation and debug.

## Interface
- N, default 4: Johnson ring width; number of slots/requesters M = 2N (N ≥ 2).
- MAX_HOLD, default 8: maximum consecutive grant cycles per grant (≥ 1).
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous, active-low reset.
- en  input  1  scan enable; gates ring advance in SCAN only.
- req  input  2N  request per requester; bit k = slot k owner.
- release  input  1  current grant holder relinquishes the resource.
- gnt  output  2N  one-hot grant; all zero when idle.
- gnt_vld  output  1  OR of gnt.
- gnt_id  output  $clog2(2N)  index of granted slot; 0 when gnt_vld=0.
- tmo  output  1  one-cycle pulse: grant revoked by hold timeout.
- ring  output  N  Johnson ring state.

## Operation
- Ring update: ring[0] <= ~ring[N-1], ring[i] <= ring[i-1]. For N=4 the legal sequence is 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000.
- Slot decode (combinational from ring): slot = popcount(ring) if ring[N-1]=0, else 2N − popcount(ring). For N=4 this gives 0000→0, 0111→3, 1111→4, 1000→7.
- Two-state FSM, SCAN and GRANT. Reset state is SCAN.
- SCAN, en=0: ring holds; no grant issued.
- SCAN, en=1, req[slot]=0: ring advances one step.
- SCAN, en=1, req[slot]=1: go to GRANT. gnt[slot] is set, the ring holds, and the hold counter loads 1.
- GRANT: gnt stays stable while req[gnt_id]=1, release=0 and hold count < MAX_HOLD. The counter increments each granted cycle. en is ignored.
- GRANT exit occurs on any of:
  - release=1;
  - req[gnt_id]=0;
  - hold count = MAX_HOLD.
  
  On exit, gnt clears, the ring advances one step (so the just-served slot is skipped) and the FSM returns to SCAN. tmo=1 only when the exit is a timeout with release=0 and req[gnt_id]=1.
- Exit and timeout in the same cycle: release or req drop takes precedence, so tmo=0.
- Fairness: each grant ends with a ring advance, so a continuous requester cannot starve the others. Worst-case wait is (2N−1)·(MAX_HOLD+1)+2N cycles.
- Wrap: slot 2N−1 advances to slot 0 (1000 → 0000 for N=4).
- Requests on non-current slots are ignored; there is no queueing.

## Timing
- Reset (clr=0) takes effect immediately, asynchronously. It forces ring=0, FSM=SCAN, gnt=0, gnt_vld=0, gnt_id=0, tmo=0 and hold count=0, including mid-grant.
- The first ring step happens at the first rising edge with clr=1 and en=1.
- All outputs are registered; there is no combinational path from req or release to gnt.
- Grant latency: req[k] sampled high at edge t with slot=k in SCAN gives gnt[k]=1 after edge t.
- Release latency: release high at edge t gives gnt=0 and ring = next state after edge t.
- Maximum grant length is MAX_HOLD cycles.
  - Timeout: gnt drops after the edge at which count=MAX_HOLD, and tmo is high for the one cycle following that edge.
- A new grant can be issued no earlier than one SCAN cycle after the previous grant drops.

## Test plan
1. Reset and free run:
   - Stimulus: clr=0 for 10 ns; then clr=1, en=1, req=0.
   - Required: ring=0000 and gnt=0 during reset; then ring steps 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000 on successive edges with a period of 8.
2. Single grant:
   - Stimulus: req=8'b0000_1000; release pulsed 3 cycles after the grant.
   - Required: ring=0111 at edge c gives gnt=8'h08 and gnt_id=3 from c. The ring holds 0111 while granted. gnt=0 and ring=1111 after the release edge.
3. Timeout (MAX_HOLD=4):
   - Stimulus: req[5] held high, release=0.
   - Required: gnt=8'h20 for exactly 4 cycles; tmo=1 for 1 cycle as gnt drops; ring=1100. Slot 5 is re-granted only after a full ring lap.
4. All requesting:
   - Stimulus: req=8'hFF; release=1 one cycle after each grant.
   - Required: gnt_id sequence 0,1,2,…,7,0, with no slot skipped or repeated.
5. Enable gating:
   - Stimulus: en=0 in SCAN at ring=0011 for 5 cycles, then en=0 during an active grant.
   - Required: ring stays 0011 for those 5 cycles; during the grant, gnt is unaffected and still exits on release.
6. Reset mid-grant:
   - Stimulus: assert clr=0 asynchronously while gnt=8'h04.
   - Required: gnt, gnt_vld, tmo and ring go to 0 immediately without waiting for clk. After clr=1, scanning restarts at slot 0.
